// File: rtl/ppr_mem_responder.sv
// rtl/ppr_mem_responder.sv - word memory responder with clear-on-reset, read/write and read-modify-write ops
module ppr_mem_responder #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8192
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [1:0]            i_op,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_err,
  output logic                  o_init_done
);

  localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [1:0]          OP_READ  = 2'b00;
  localparam logic [1:0]          OP_WRITE = 2'b01;
  localparam logic [1:0]          OP_INC   = 2'b10;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RMW_WB} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        clr_addr_q, clr_addr_d;
  logic                    init_done_q, init_done_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [IDX_W-1:0]        rmw_addr_q, rmw_addr_d;
  logic [DATA_WIDTH-1:0]   rmw_old_q, rmw_old_d;
  logic [DATA_WIDTH-1:0]   rmw_addend_q, rmw_addend_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    mem_we;
  logic [IDX_W-1:0]        mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic [DATA_WIDTH-1:0]   rmw_sum;
  logic [IDX_W-1:0]        req_idx;
  logic                    in_range;
  logic                    accept;

  assign req_idx      = i_addr[IDX_W-1:0];
  assign in_range     = {1'b0, i_addr} < DEPTH_X;
  assign o_req_ready  = (state_q == ST_IDLE);
  assign accept       = i_req_valid && o_req_ready;
  assign mem_rdata    = mem[mem_addr];
  assign rmw_sum      = rmw_old_q + rmw_addend_q;
  assign o_resp_valid = resp_valid_q;
  assign o_err        = err_q;
  assign o_data       = data_q;
  assign o_init_done  = init_done_q;

  // The single memory port is steered by state: clear counter, request address, or writeback address.
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    init_done_d  = init_done_q;
    resp_valid_d = 1'b0;
    err_d        = 1'b0;
    data_d       = data_q;
    rmw_addr_d   = rmw_addr_q;
    rmw_old_d    = rmw_old_q;
    rmw_addend_d = rmw_addend_q;
    mem_we       = 1'b0;
    mem_addr     = req_idx;
    mem_wdata    = i_data;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_addr  = clr_addr_q;
        mem_wdata = '0;
        if (clr_addr_q == LAST_IDX) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
          clr_addr_d  = '0;
        end else begin
          clr_addr_d = clr_addr_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (accept) begin
          if (!in_range) begin
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            data_d       = '0;
          end else if (i_op == OP_READ) begin
            resp_valid_d = 1'b1;
            data_d       = mem_rdata;
          end else if (i_op == OP_WRITE) begin
            mem_we       = 1'b1;
            resp_valid_d = 1'b1;
            data_d       = i_data;
          end else begin
            rmw_addr_d   = req_idx;
            rmw_old_d    = mem_rdata;
            rmw_addend_d = (i_op == OP_INC) ? DATA_WIDTH'(1) : i_data;
            state_d      = ST_RMW_WB;
          end
        end
      end
      ST_RMW_WB: begin
        mem_we       = 1'b1;
        mem_addr     = rmw_addr_q;
        mem_wdata    = rmw_sum;
        resp_valid_d = 1'b1;
        data_d       = rmw_sum;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_INIT;
      clr_addr_q   <= '0;
      init_done_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      data_q       <= '0;
      rmw_addr_q   <= '0;
      rmw_old_q    <= '0;
      rmw_addend_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      init_done_q  <= init_done_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      data_q       <= data_d;
      rmw_addr_q   <= rmw_addr_d;
      rmw_old_q    <= rmw_old_d;
      rmw_addend_q <= rmw_addend_d;
    end
  end

  // Array has no reset; contents only become defined once the clear sweep finishes.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_rst) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_ppr_mem_responder.sv
// tb/tb_ppr_mem_responder.sv - randomized self-checking bench for ppr_mem_responder
module tb_ppr_mem_responder;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    op = 2'b00;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          resp_valid;
  logic [DW-1:0] rdata;
  logic          err;
  logic          init_done;

  int n_pass = 0;
  int n_total = 0;
  logic [DW-1:0] model_mem [DEPTH];

  ppr_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_op(op), .i_addr(addr), .i_data(wdata), .o_resp_valid(resp_valid),
    .o_data(rdata), .o_err(err), .o_init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: what a request should produce, in terms of value, error and latency.
  task automatic model_op(input logic [1:0] mop, input logic [AW-1:0] maddr, input logic [DW-1:0] mdata,
                          output logic [DW-1:0] ed, output logic ee, output int el);
    ee = 1'b0;
    el = 1;
    if (int'(maddr) >= DEPTH) begin
      ed = '0;
      ee = 1'b1;
    end else begin
      case (mop)
        2'b00: ed = model_mem[maddr];
        2'b01: begin model_mem[maddr] = mdata; ed = mdata; end
        2'b10: begin model_mem[maddr] = model_mem[maddr] + 32'd1; ed = model_mem[maddr]; el = 2; end
        default: begin model_mem[maddr] = model_mem[maddr] + mdata; ed = model_mem[maddr]; el = 2; end
      endcase
    end
  endtask

  task automatic issue(input logic [1:0] iop, input logic [AW-1:0] iaddr, input logic [DW-1:0] idata,
                       output logic [DW-1:0] od, output logic oe, output int lat);
    logic acc = 1'b0;
    logic rdy_now;
    req_valid = 1'b1; op = iop; addr = iaddr; wdata = idata;
    for (int k = 0; k < 8 && !acc; k++) begin
      rdy_now = req_ready;
      tick();
      if (rdy_now) acc = 1'b1;
    end
    req_valid = 1'b0;
    lat = acc ? 1 : 9;
    while (!resp_valid && lat < 6) begin
      tick();
      lat++;
    end
    od = rdata;
    oe = err;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic test_reset();
    int early_ready = 0;
    rst = 1'b1;
    tick(); tick();
    n_total++;
    if ({req_ready, resp_valid, err, init_done} !== 4'b0000 || rdata !== 32'd0) begin
      $display("FAIL reset_outputs: rdy/rv/err/done=%b data=%h required 0000 data=0",
               {req_ready, resp_valid, err, init_done}, rdata);
    end else n_pass++;
    rst = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (req_ready || init_done) early_ready++;
    end
    n_total++;
    if (early_ready !== 0) $display("FAIL init_ready_low: %0d early cycles required 0", early_ready);
    else n_pass++;
    tick();
    n_total++;
    if ({req_ready, init_done} !== 2'b11) $display("FAIL init_done: rdy/done=%b required 11", {req_ready, init_done});
    else n_pass++;
    clear_model();
  endtask

  task automatic test_init_reads();
    int bad = 0;
    req_valid = 1'b1; op = 2'b00;
    for (int i = 0; i < DEPTH; i++) begin
      addr = AW'(i);
      tick();
      if (!resp_valid || rdata !== model_mem[i] || err) bad++;
    end
    req_valid = 1'b0;
    n_total++;
    if (bad !== 0) $display("FAIL init_reads: %0d bad responses required 0", bad);
    else n_pass++;
    tick();
    n_total++;
    if (resp_valid !== 1'b0) $display("FAIL resp_strobe_drop: resp_valid=%b required 0", resp_valid);
    else n_pass++;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d, ed; logic e, ee; int l, el;
    model_op(2'b01, 5'd3, 32'h0000_00AA, ed, ee, el);
    issue(2'b01, 5'd3, 32'h0000_00AA, d, e, l);
    n_total++;
    if (d !== ed || e !== ee || l !== el) $display("FAIL write3: data=%h err=%b lat=%0d required %h %b %0d", d, e, l, ed, ee, el);
    else n_pass++;
    model_op(2'b00, 5'd3, 32'h0, ed, ee, el);
    issue(2'b00, 5'd3, 32'h0, d, e, l);
    n_total++;
    if (d !== ed || e !== ee || l !== el) $display("FAIL read3: data=%h err=%b lat=%0d required %h %b %0d", d, e, l, ed, ee, el);
    else n_pass++;
  endtask

  task automatic test_increment();
    logic [DW-1:0] base, d, ed; logic e, ee; int l, el; int bad = 0;
    base = model_mem[5];
    req_valid = 1'b1; op = 2'b10; addr = 5'd5;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (req_ready !== ((t % 2) == 0)) bad++;
      if (resp_valid !== ((t % 2) == 0)) bad++;
      if ((t % 2) == 0 && rdata !== base + DW'(t / 2)) bad++;
    end
    req_valid = 1'b0;
    model_mem[5] = base + 32'd3;
    n_total++;
    if (bad !== 0) $display("FAIL inc_held: %0d deviations required 0", bad);
    else n_pass++;
    model_op(2'b00, 5'd5, 32'h0, ed, ee, el);
    issue(2'b00, 5'd5, 32'h0, d, e, l);
    n_total++;
    if (d !== ed || e !== ee || l !== el) $display("FAIL read5: data=%h err=%b lat=%0d required %h %b %0d", d, e, l, ed, ee, el);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [1:0] ops [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    logic [DW-1:0] dats [4] = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE, 32'h5};
    logic [DW-1:0] d, ed; logic e, ee; int l, el;
    for (int i = 0; i < 4; i++) begin
      model_op(ops[i], 5'd7, dats[i], ed, ee, el);
      issue(ops[i], 5'd7, dats[i], d, e, l);
      n_total++;
      if (d !== ed || e !== ee || l !== el)
        $display("FAIL wrap_%0d: data=%h err=%b lat=%0d required %h %b %0d", i, d, e, l, ed, ee, el);
      else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] ops [5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    logic [AW-1:0] ads [5] = '{5'd20, 5'd20, 5'd16, 5'd31, 5'd15};
    logic [DW-1:0] d, ed; logic e, ee; int l, el; int bad = 0;
    for (int i = 0; i < 5; i++) begin
      model_op(ops[i], ads[i], 32'h1234, ed, ee, el);
      issue(ops[i], ads[i], 32'h1234, d, e, l);
      n_total++;
      if (d !== ed || e !== ee || l !== el)
        $display("FAIL oor_%0d: data=%h err=%b lat=%0d required %h %b %0d", i, d, e, l, ed, ee, el);
      else n_pass++;
    end
    for (int i = 0; i < DEPTH; i++) begin
      model_op(2'b00, AW'(i), 32'h0, ed, ee, el);
      issue(2'b00, AW'(i), 32'h0, d, e, l);
      if (d !== ed || e !== ee) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL oor_untouched: %0d words differ required 0", bad);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] rop; logic [AW-1:0] rad; logic [DW-1:0] rd;
    logic [DW-1:0] d, ed; logic e, ee; int l, el;
    int bad = 0, idle_bad = 0;
    for (int n = 0; n < 200; n++) begin
      rop = 2'($urandom_range(0, 3));
      rad = AW'($urandom_range(0, 19));
      rd  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      model_op(rop, rad, rd, ed, ee, el);
      issue(rop, rad, rd, d, e, l);
      if (d !== ed || e !== ee || l !== el) begin
        if (bad < 5) $display("FAIL rand_%0d: op=%0d addr=%0d data=%h err=%b lat=%0d required %h %b %0d",
                              n, rop, rad, d, e, l, ed, ee, el);
        bad++;
      end
      if ($urandom_range(0, 3) == 0) begin
        tick();
        if (resp_valid || err) idle_bad++;
      end
    end
    n_total++;
    if (bad !== 0) $display("FAIL rand_total: %0d bad responses required 0", bad);
    else n_pass++;
    n_total++;
    if (idle_bad !== 0) $display("FAIL rand_idle_strobes: %0d spurious required 0", idle_bad);
    else n_pass++;
  endtask

  task automatic test_reset_in_rmw();
    logic [DW-1:0] d, ed; logic e, ee; int l, el; int bad = 0; int spurious = 0;
    model_op(2'b01, 5'd2, 32'd9, ed, ee, el);
    issue(2'b01, 5'd2, 32'd9, d, e, l);
    req_valid = 1'b1; op = 2'b10; addr = 5'd2;
    tick();
    req_valid = 1'b0;
    n_total++;
    if (req_ready !== 1'b0) $display("FAIL rmw_ready_low: ready=%b required 0", req_ready);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({req_ready, resp_valid, err, init_done} !== 4'b0000 || rdata !== 32'd0)
      $display("FAIL rmw_reset_now: rdy/rv/err/done=%b data=%h required 0000 data=0",
               {req_ready, resp_valid, err, init_done}, rdata);
    else n_pass++;
    tick(); tick();
    rst = 1'b0;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (resp_valid) spurious++;
      if (req_ready !== (t == 16)) bad++;
    end
    n_total++;
    if (spurious !== 0 || bad !== 0) $display("FAIL rmw_reset_reinit: spurious=%0d ready_dev=%0d required 0 0", spurious, bad);
    else n_pass++;
    clear_model();
    model_op(2'b00, 5'd2, 32'h0, ed, ee, el);
    issue(2'b00, 5'd2, 32'h0, d, e, l);
    n_total++;
    if (d !== ed || e !== ee || l !== el) $display("FAIL read2_after_reset: data=%h err=%b lat=%0d required %h %b %0d", d, e, l, ed, ee, el);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init_reads();
    test_write_read();
    test_increment();
    test_wrap();
    test_out_of_range();
    test_random();
    test_reset_in_rmw();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
